tape_recorder: RTL and testbench
================================

Name: tape_recorder

Overview:
- Capture side of the tape subsystem: decodes the Spectrum SAVE waveform (ROM-timed MIC/EAR output level) into TAP-format blocks in the shared tape buffer.
- Output is directly playable by the TAP player, and feeds the SAVE-to-file path.
- Measures half-period lengths in T-states (ce ticks at 3.5 MHz), detects pilot/sync, assembles bytes MSB-first, and writes each block as 2-byte little-endian length + data.

Parameters:
- PILOT_MIN, 256: consecutive pilot half-periods required before a sync is accepted.
- TIMEOUT, 350000: ce ticks without an edge that end a data block (100 ms).
- BUF_SIZE, 25'h1000000: buffer capacity in bytes; writes never reach address BUF_SIZE.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  3.5 MHz T-state enable; all timing counts ce ticks
- rec  in  1  recording enabled; falling edge finalises any open block
- mic_in  in  1  tape output level (port FE bit 3), clk_sys-synchronous
- wr  out  1  buffer write request, held until acknowledged
- wr_addr  out  25  write byte address
- wr_data  out  8  write data
- wr_ack  in  1  one-cycle acknowledge; request retires on this cycle
- active  out  1  state != IDLE
- tape_size  out  25  total bytes of completed blocks (next block base)
- blk_cnt  out  8  completed blocks, wraps at 255
- chk_ok  out  1  XOR of all bytes of last completed block == 0
- overflow  out  1  sticky: byte dropped (write pending) or buffer full

Behaviour:
- Reset (async, reset_n=0):
  - wr=0; wr_addr=0; wr_data=0; active=0; tape_size=0; blk_cnt=0; chk_ok=0; overflow=0.
  - State IDLE, base=0.
- Edge timing:
  - On ce, compare mic_in to its previous ce sample.
  - half_len is a 16-bit counter, saturating at 65535, incremented every ce.
  - On an edge, H=half_len is latched and half_len restarts at 1.
  - idle_cnt counts ce since the last edge and clears on each edge.
- Classes:
  - PIL: H in 1800..2600.
  - SYN: H in 400..1000.
  - Data bit: pair sum in 1200..2200 = 0; pair sum in 2800..4000 = 1; any other sum is invalid.
- IDLE:
  - When rec=1 and an edge with H=PIL occurs: pilot_cnt=1, enter PILOT.
  - When rec=0, stay in IDLE and ignore all edges.
- PILOT:
  - PIL edge: pilot_cnt++, saturating.
  - SYN edge with pilot_cnt>=PILOT_MIN: enter SYNC.
  - Any other edge: enter IDLE.
- SYNC:
  - Next edge SYN: enter DATA with len=0, chk=0, bitcnt=0, half phase=first.
  - Otherwise enter IDLE.
- DATA:
  - Edges are taken in pairs.
  - On the second edge: sum=H1+H2, 17-bit.
    - Valid sum: shift bit into sreg.
    - After 8 bits: byte to hold register, address base+2+len; len++ (16-bit); chk^=byte.
    - Invalid sum: end block.
  - Also end block on idle_cnt==TIMEOUT, on rec falling, or when len reaches 65535.
  - End of block:
    - Partial bits are discarded.
    - len==0: enter IDLE, nothing stored.
    - Otherwise enter FIN_WAIT.
- Write port:
  - A single holding register; wr rises the cycle after a byte completes.
  - The request clears on the wr_ack cycle.
  - A byte completing while wr=1 without ack in the same cycle: byte dropped, overflow=1; len and chk still advance.
  - Address >= BUF_SIZE: byte dropped, overflow=1.
- FIN_WAIT: wait until wr=0, then enter FIN_LO.
- FIN_LO: write len[7:0] to base; on ack, enter FIN_HI.
- FIN_HI:
  - Write len[15:8] to base+1.
  - On ack:
    - base += 2+len; tape_size = new base.
    - blk_cnt++; chk_ok = (chk==0).
    - Enter IDLE.
- Block overflow: if base+2+len would exceed BUF_SIZE, the block is still finalised with its length, but tape_size is clamped to BUF_SIZE and overflow=1.
- Simultaneous events: rec falling in the same cycle as a completing byte includes that byte first, then finalises.
- Mid-operation reset: reset_n low at any time, including during FIN_LO/FIN_HI, aborts immediately and returns to reset values. A partial block is lost.

Test Plan:
- 300 halves of 2168, syncs 667/735, bytes 0x00,0xFF,0xFF, pairs 855/855 or 1710/1710, then 200 ms silence:
  - Writes 0x00,0xFF,0xFF to addresses 2,3,4, then 0x03 to 0, 0x00 to 1.
  - tape_size=5; blk_cnt=1; chk_ok=1.
- Two blocks back to back (len 2 then len 1):
  - Second block base=4, data at 6, length at 4/5.
  - tape_size=7; blk_cnt=2.
- Only 100 pilot halves then sync: no writes; active returns to 0.
- Hold wr_ack low 20000 ce ticks during a block:
  - Next byte is dropped; overflow=1.
  - len still counts, so the length field equals the bytes received.
- rec dropped after 5 bits of the 2nd byte: only the 1st byte is stored; length field=1.
- reset_n pulsed low during FIN_HI: all outputs zero next cycle; blk_cnt=0.

Source files
------------

// File: rtl/tape_recorder.sv
// Decodes the ROM SAVE waveform (MIC level, timed in ce T-states) into TAP blocks:
// a 2-byte little-endian length followed by the data bytes, written through a one-deep write port.
module tape_recorder #(
  parameter int unsigned PILOT_MIN = 256,
  parameter int unsigned TIMEOUT   = 350000,
  parameter logic [24:0] BUF_SIZE  = 25'h1000000,
  parameter int unsigned TDIV      = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        rec,
  input  logic        mic_in,
  output logic        wr,
  output logic [24:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  output logic        active,
  output logic [24:0] tape_size,
  output logic [7:0]  blk_cnt,
  output logic        chk_ok,
  output logic        overflow
);

  // TDIV scales every timing window together; 1 gives real ROM timings.
  localparam logic [15:0] PIL_LO = 16'(1800 / TDIV);
  localparam logic [15:0] PIL_HI = 16'(2600 / TDIV);
  localparam logic [15:0] SYN_LO = 16'(400 / TDIV);
  localparam logic [15:0] SYN_HI = 16'(1000 / TDIV);
  localparam logic [16:0] B0_LO  = 17'(1200 / TDIV);
  localparam logic [16:0] B0_HI  = 17'(2200 / TDIV);
  localparam logic [16:0] B1_LO  = 17'(2800 / TDIV);
  localparam logic [16:0] B1_HI  = 17'(4000 / TDIV);
  localparam logic [15:0] PMIN   = 16'(PILOT_MIN);
  localparam int unsigned IW     = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TO_V = IW'(TIMEOUT);
  localparam logic [25:0] BUF_LIM = {1'b0, BUF_SIZE};

  typedef enum logic [2:0] {
    S_IDLE, S_PILOT, S_SYNC, S_DATA, S_FIN_WAIT, S_FIN_LO, S_FIN_HI
  } state_t;

  state_t        state_q;
  logic          mic_q, rec_q, phase_q;
  logic [15:0]   half_q, h1_q, pilot_q, len_q;
  logic [IW-1:0] idle_q;
  logic [2:0]    bitcnt_q;
  logic [6:0]    sreg_q;
  logic [7:0]    chk_q, blk_q, data_q;
  logic [24:0]   base_q, addr_q, tsize_q;
  logic          wr_q, chk_ok_q, ovf_q;

  logic        mic_edge, rec_fall, is_pil, is_syn, bit_one, bit_ok;
  logic        pair_done, bit_in, byte_done, end_blk;
  logic [16:0] sum_d;
  logic [7:0]  sreg_d, chk_d;
  logic [15:0] len_d, len_eff;
  logic [25:0] nxt_addr, base_p1;

  assign mic_edge  = ce && (mic_in != mic_q);
  assign rec_fall  = rec_q && !rec;
  assign is_pil    = (half_q >= PIL_LO) && (half_q <= PIL_HI);
  assign is_syn    = (half_q >= SYN_LO) && (half_q <= SYN_HI);
  assign sum_d     = {1'b0, h1_q} + {1'b0, half_q};
  assign bit_one   = (sum_d >= B1_LO) && (sum_d <= B1_HI);
  assign bit_ok    = bit_one || ((sum_d >= B0_LO) && (sum_d <= B0_HI));
  assign pair_done = (state_q == S_DATA) && mic_edge && phase_q;
  assign bit_in    = pair_done && bit_ok;
  assign byte_done = bit_in && (bitcnt_q == 3'd7);
  assign sreg_d    = {sreg_q, bit_one};
  assign len_d     = len_q + 16'd1;
  assign chk_d     = chk_q ^ sreg_d;
  assign len_eff   = byte_done ? len_d : len_q;
  assign nxt_addr  = {1'b0, base_q} + 26'd2 + {10'd0, len_q};
  assign base_p1   = {1'b0, base_q} + 26'd1;
  // A byte completing on the same cycle as an end condition is counted before finalising.
  assign end_blk   = (pair_done && !bit_ok) || (idle_q == TO_V) || rec_fall ||
                     (byte_done && (len_d == 16'hFFFF));

  assign wr        = wr_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign active    = (state_q != S_IDLE);
  assign tape_size = tsize_q;
  assign blk_cnt   = blk_q;
  assign chk_ok    = chk_ok_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mic_q    <= 1'b0;
      rec_q    <= 1'b0;
      phase_q  <= 1'b0;
      half_q   <= '0;
      h1_q     <= '0;
      pilot_q  <= '0;
      len_q    <= '0;
      idle_q   <= '0;
      bitcnt_q <= '0;
      sreg_q   <= '0;
      chk_q    <= '0;
      blk_q    <= '0;
      data_q   <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      tsize_q  <= '0;
      wr_q     <= 1'b0;
      chk_ok_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rec_q <= rec;
      if (ce) begin
        mic_q <= mic_in;
        if (mic_edge) begin
          half_q <= 16'd1;
          idle_q <= '0;
        end else begin
          if (half_q != 16'hFFFF) half_q <= half_q + 16'd1;
          if (idle_q != TO_V)     idle_q <= idle_q + 1'b1;
        end
      end
      if (wr_q && wr_ack) wr_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (rec && mic_edge && is_pil) begin
            pilot_q <= 16'd1;
            state_q <= S_PILOT;
          end
        end
        S_PILOT: begin
          if (rec_fall) state_q <= S_IDLE;
          else if (mic_edge) begin
            if (is_pil) begin
              if (pilot_q != 16'hFFFF) pilot_q <= pilot_q + 16'd1;
            end else if (is_syn && (pilot_q >= PMIN)) state_q <= S_SYNC;
            else state_q <= S_IDLE;
          end
        end
        S_SYNC: begin
          if (rec_fall) state_q <= S_IDLE;
          else if (mic_edge) begin
            if (is_syn) begin
              state_q  <= S_DATA;
              len_q    <= '0;
              chk_q    <= '0;
              bitcnt_q <= '0;
              phase_q  <= 1'b0;
            end else state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (mic_edge) begin
            phase_q <= !phase_q;
            if (!phase_q) h1_q <= half_q;
          end
          if (bit_in) begin
            sreg_q   <= sreg_d[6:0];
            bitcnt_q <= bitcnt_q + 3'd1;
          end
          if (byte_done) begin
            len_q <= len_d;
            chk_q <= chk_d;
            if ((wr_q && !wr_ack) || (nxt_addr >= BUF_LIM)) ovf_q <= 1'b1;
            else begin
              wr_q   <= 1'b1;
              addr_q <= nxt_addr[24:0];
              data_q <= sreg_d;
            end
          end
          if (end_blk) state_q <= (len_eff == 16'd0) ? S_IDLE : S_FIN_WAIT;
        end
        S_FIN_WAIT: begin
          if (!wr_q) begin
            state_q <= S_FIN_LO;
            if ({1'b0, base_q} < BUF_LIM) begin
              wr_q   <= 1'b1;
              addr_q <= base_q;
              data_q <= len_q[7:0];
            end else ovf_q <= 1'b1;
          end
        end
        S_FIN_LO: begin
          // A length byte that could not be issued is skipped rather than stalling.
          if (!wr_q || wr_ack) begin
            state_q <= S_FIN_HI;
            if (base_p1 < BUF_LIM) begin
              wr_q   <= 1'b1;
              addr_q <= base_p1[24:0];
              data_q <= len_q[15:8];
            end else ovf_q <= 1'b1;
          end
        end
        S_FIN_HI: begin
          if (!wr_q || wr_ack) begin
            state_q  <= S_IDLE;
            blk_q    <= blk_q + 8'd1;
            chk_ok_q <= (chk_q == 8'd0);
            if (nxt_addr > BUF_LIM) begin
              base_q  <= BUF_SIZE;
              tsize_q <= BUF_SIZE;
              ovf_q   <= 1'b1;
            end else begin
              base_q  <= nxt_addr[24:0];
              tsize_q <= nxt_addr[24:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_recorder.sv
// Bench for tape_recorder: synthesised SAVE waveforms with timings scaled by TDIV, write scoreboard.
module tb_tape_recorder;

  localparam int TDIV = 25, PMIN = 16, TOUT = 400;
  localparam int P_HALF = 87, S1 = 27, S2 = 29, B0 = 34, B1 = 68;
  localparam int NPIL = 18, SIL = 600;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        ce = 1'b0;
  logic        reset_n, rec, mic_in, wr_ack;
  logic        wr, active, chk_ok, overflow;
  logic [24:0] wr_addr, tape_size;
  logic [7:0]  wr_data, blk_cnt;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  wr_seen = 0;
  bit  ack_en = 1'b1;

  tape_recorder #(
    .PILOT_MIN(PMIN), .TIMEOUT(TOUT), .BUF_SIZE(25'h1000000), .TDIV(TDIV)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .rec(rec), .mic_in(mic_in),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .active(active), .tape_size(tape_size), .blk_cnt(blk_cnt),
    .chk_ok(chk_ok), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;
  always @(negedge clk_sys) ce = ~ce;

  function automatic wr_t mk(input logic [24:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // Acks a pending write for one cycle and scores it against the expected queue.
  task automatic responder();
    wr_t e;
    forever begin
      @(negedge clk_sys);
      if (wr_ack) wr_ack = 1'b0;
      else if (wr && ack_en) begin
        wr_ack = 1'b1;
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got addr=%0h data=%0h exp none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL write got addr=%0h data=%0h exp addr=%0h data=%0h",
                     wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      while (!ce) @(posedge clk_sys);
    end
  endtask

  task automatic half(input int n);
    @(negedge clk_sys);
    mic_in = ~mic_in;
    tick_wait(n);
  endtask

  task automatic send_lead(input int npil);
    tick_wait(100);
    repeat (npil) half(P_HALF);
    half(S1);
    half(S2);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    logic [7:0] s;
    s = v;
    for (int i = 0; i < n; i++) begin
      half(s[7] ? B1 : B0);
      half(s[7] ? B1 : B0);
      s = s << 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    rec     = 1'b1;
    mic_in  = 1'b0;
    ack_en  = 1'b1;
    wr_seen = 0;
    exp_q.delete();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++; if (wr !== 1'b0) begin failures++; $display("FAIL rst_wr got=%0b exp=0", wr); end
    checks++; if (wr_addr !== 25'd0 || wr_data !== 8'd0) begin failures++; $display("FAIL rst_wr_bus got=%0h/%0h exp=0/0", wr_addr, wr_data); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL rst_active got=%0b exp=0", active); end
    checks++; if (tape_size !== 25'd0 || blk_cnt !== 8'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", tape_size, blk_cnt); end
    checks++; if (chk_ok !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b/%0b exp=0/0", chk_ok, overflow); end
    apply_reset();
  endtask

  task automatic test_single_block();
    apply_reset();
    exp_q.push_back(mk(25'd2, 8'h00));
    exp_q.push_back(mk(25'd3, 8'hFF));
    exp_q.push_back(mk(25'd4, 8'hFF));
    exp_q.push_back(mk(25'd0, 8'h03));
    exp_q.push_back(mk(25'd1, 8'h00));
    send_lead(NPIL);
    send_bits(8'h00, 8);
    send_bits(8'hFF, 8);
    send_bits(8'hFF, 8);
    half(SIL);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_writes got=%0d pending exp=0", exp_q.size()); end
    checks++; if (tape_size !== 25'd5) begin failures++; $display("FAIL single_tape_size got=%0d exp=5", tape_size); end
    checks++; if (blk_cnt !== 8'd1) begin failures++; $display("FAIL single_blk_cnt got=%0d exp=1", blk_cnt); end
    checks++; if (chk_ok !== 1'b1) begin failures++; $display("FAIL single_chk_ok got=%0b exp=1", chk_ok); end
    checks++; if (overflow !== 1'b0 || active !== 1'b0) begin failures++; $display("FAIL single_ovf_active got=%0b/%0b exp=0/0", overflow, active); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    exp_q.push_back(mk(25'd2, 8'h12));
    exp_q.push_back(mk(25'd3, 8'h34));
    exp_q.push_back(mk(25'd0, 8'h02));
    exp_q.push_back(mk(25'd1, 8'h00));
    send_lead(NPIL);
    send_bits(8'h12, 8);
    send_bits(8'h34, 8);
    half(SIL);
    checks++; if (tape_size !== 25'd4 || blk_cnt !== 8'd1) begin failures++; $display("FAIL b2b_first got=%0d/%0d exp=4/1", tape_size, blk_cnt); end
    checks++; if (chk_ok !== 1'b0) begin failures++; $display("FAIL b2b_first_chk got=%0b exp=0", chk_ok); end
    exp_q.push_back(mk(25'd6, 8'h00));
    exp_q.push_back(mk(25'd4, 8'h01));
    exp_q.push_back(mk(25'd5, 8'h00));
    send_lead(NPIL);
    send_bits(8'h00, 8);
    half(SIL);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_writes got=%0d pending exp=0", exp_q.size()); end
    checks++; if (tape_size !== 25'd7) begin failures++; $display("FAIL b2b_tape_size got=%0d exp=7", tape_size); end
    checks++; if (blk_cnt !== 8'd2) begin failures++; $display("FAIL b2b_blk_cnt got=%0d exp=2", blk_cnt); end
    checks++; if (chk_ok !== 1'b1) begin failures++; $display("FAIL b2b_second_chk got=%0b exp=1", chk_ok); end
  endtask

  task automatic test_short_pilot();
    apply_reset();
    tick_wait(100);
    repeat (5) half(P_HALF);
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL short_pilot_active got=%0b exp=1", active); end
    half(S1);
    half(S2);
    send_bits(8'h42, 8);
    half(SIL);
    checks++; if (wr_seen != 0) begin failures++; $display("FAIL short_pilot_writes got=%0d exp=0", wr_seen); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL short_pilot_idle got=%0b exp=0", active); end
    checks++; if (blk_cnt !== 8'd0 || tape_size !== 25'd0) begin failures++; $display("FAIL short_pilot_counts got=%0d/%0d exp=0/0", blk_cnt, tape_size); end
  endtask

  task automatic test_ack_stall();
    apply_reset();
    ack_en = 1'b0;
    exp_q.push_back(mk(25'd2, 8'h5A));
    exp_q.push_back(mk(25'd4, 8'h66));
    exp_q.push_back(mk(25'd0, 8'h03));
    exp_q.push_back(mk(25'd1, 8'h00));
    send_lead(NPIL);
    send_bits(8'h5A, 8);
    send_bits(8'h3C, 8);
    send_bits(8'h66, 1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL stall_overflow got=%0b exp=1", overflow); end
    ack_en = 1'b1;
    send_bits(8'hCC, 7);
    half(SIL);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_writes got=%0d pending exp=0", exp_q.size()); end
    checks++; if (tape_size !== 25'd5 || blk_cnt !== 8'd1) begin failures++; $display("FAIL stall_counts got=%0d/%0d exp=5/1", tape_size, blk_cnt); end
    checks++; if (chk_ok !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL stall_flags got=%0b/%0b exp=1/1", chk_ok, overflow); end
  endtask

  task automatic test_rec_drop();
    apply_reset();
    exp_q.push_back(mk(25'd2, 8'hA5));
    exp_q.push_back(mk(25'd0, 8'h01));
    exp_q.push_back(mk(25'd1, 8'h00));
    send_lead(NPIL);
    send_bits(8'hA5, 8);
    send_bits(8'hC3, 5);
    half(B0);
    @(negedge clk_sys);
    rec = 1'b0;
    tick_wait(SIL);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL recdrop_writes got=%0d pending exp=0", exp_q.size()); end
    checks++; if (tape_size !== 25'd3 || blk_cnt !== 8'd1) begin failures++; $display("FAIL recdrop_counts got=%0d/%0d exp=3/1", tape_size, blk_cnt); end
    checks++; if (chk_ok !== 1'b0 || active !== 1'b0) begin failures++; $display("FAIL recdrop_flags got=%0b/%0b exp=0/0", chk_ok, active); end
  endtask

  task automatic test_reset_in_fin();
    int n;
    apply_reset();
    exp_q.push_back(mk(25'd2, 8'h81));
    exp_q.push_back(mk(25'd0, 8'h01));
    send_lead(NPIL);
    send_bits(8'h81, 8);
    @(negedge clk_sys);
    mic_in = ~mic_in;
    n = 0;
    while (wr_seen < 2 && n < 3000) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    ack_en = 1'b0;
    checks++; if (wr_seen < 2) begin failures++; $display("FAIL finhi_reach got=%0d writes exp=2", wr_seen); end
    repeat (4) @(posedge clk_sys);
    #1;
    checks++; if (wr !== 1'b1 || wr_addr !== 25'd1 || wr_data !== 8'h00) begin failures++; $display("FAIL finhi_pending got=%0b/%0h/%0h exp=1/1/0", wr, wr_addr, wr_data); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (wr !== 1'b0 || wr_addr !== 25'd0 || wr_data !== 8'd0 || active !== 1'b0) begin failures++; $display("FAIL finhi_async got=%0b/%0h/%0h/%0b exp=0/0/0/0", wr, wr_addr, wr_data, active); end
    @(posedge clk_sys);
    #1;
    checks++; if (blk_cnt !== 8'd0 || tape_size !== 25'd0 || chk_ok !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL finhi_cleared got=%0d/%0d/%0b/%0b exp=0/0/0/0", blk_cnt, tape_size, chk_ok, overflow); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL finhi_writes got=%0d pending exp=0", exp_q.size()); end
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    rec     = 1'b1;
    mic_in  = 1'b0;
    wr_ack  = 1'b0;
    fork
      responder();
    join_none
    test_reset();
    test_single_block();
    test_back_to_back();
    test_short_pilot();
    test_ack_stall();
    test_rec_drop();
    test_reset_in_fin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
